// File: rtl/vga_wb_arb.sv
// Two-master Wishbone arbiter: registered round-robin grant, combinational slave mux.
// Optional watchdog enabled by the macro VGA_WB_ARB_TIMEOUT_EN.
module vga_wb_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_nreset_i,
  input  logic [31:2] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_cab_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:2] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_cab_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:2] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_cab_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o,
  output logic        arb_to_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   stb_raw;
  logic   expire;

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Ties go to whichever master did not own the bus last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: if (!m0_cyc_i) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
      OWN1: if (!m1_cyc_i) begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o = {state_q == OWN1, state_q == OWN0};

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_cab_o = 1'b0;
    stb_raw = 1'b0;
    case (state_q)
      OWN0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_cab_o = m0_cab_i;
        stb_raw = m0_stb_i;
      end
      OWN1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_cab_o = m1_cab_i;
        stb_raw = m1_stb_i;
      end
      default: ;
    endcase
  end

`ifdef VGA_WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       stall;

  assign stall  = stb_raw & ~s_ack_i & ~s_err_i;
  assign expire = stall & (cnt_q == TO_LIM);

  always_comb begin
    cnt_d = '0;
    if (stall && !expire) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign expire         = 1'b0;
`endif

  assign s_stb_o  = stb_raw & ~expire;
  assign arb_to_o = expire;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_o[0];
  assign m1_ack_o = s_ack_i & gnt_o[1];
  assign m0_err_o = (s_err_i | expire) & gnt_o[0];
  assign m1_err_o = (s_err_i | expire) & gnt_o[1];

endmodule

// File: doc/vga_wb_arb.md
# vga_wb_arb

Two-master Wishbone arbiter that sits directly downstream of the VGA/CLUT wrapper's master port. It shares one system-memory slave bus between the VGA pixel fetcher (m0, burst reads with CAB) and a host/DMA master (m1). Grant is registered and round-robin on ties. An optional watchdog terminates cycles the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: watchdog limit in wb_clk_i cycles (8-bit counter, 1..255).

Ports (name, direction, width, meaning):
- wb_clk_i, in, 1: Wishbone clock (sole clock).
- rst_nreset_i, in, 1: reset, asynchronous, active-low.
- m0_adr_i / m1_adr_i, in, 30 [31:2]: master address.
- m0_dat_i / m1_dat_i, in, 32: master write data.
- m0_dat_o / m1_dat_o, out, 32: read data; both driven from s_dat_i unconditionally.
- m0_sel_i / m1_sel_i, in, 4: byte selects.
- m0_we_i / m1_we_i, in, 1: write enable.
- m0_stb_i / m1_stb_i, in, 1: strobe.
- m0_cyc_i / m1_cyc_i, in, 1: bus request / cycle valid.
- m0_cab_i / m1_cab_i, in, 1: continuous address burst.
- m0_ack_o / m1_ack_o, out, 1: acknowledge, owner only.
- m0_err_o / m1_err_o, out, 1: error, owner only.
- s_adr_o [31:2], s_dat_o [31:0], s_sel_o [3:0], s_we_o, s_stb_o, s_cyc_o, s_cab_o, out: slave bus, muxed from the owner.
- s_dat_i, in, 32: slave read data.
- s_ack_i / s_err_i, in, 1: slave acknowledge / error.
- gnt_o, out, 2: one-hot grant, {m1,m0}; 2'b00 when idle.
- arb_to_o, out, 1: one-cycle watchdog-expiry pulse.

## Operation
- States: IDLE, OWN0, OWN1. Registered; last_owner flag, reset value 1 (m1).
- IDLE:
  - Only m0_cyc_i high: go to OWN0.
  - Only m1_cyc_i high: go to OWN1.
  - Both high: grant the master that is not last_owner.
  - Neither: stay in IDLE.
- OWNx: stay while mx_cyc_i is high. Any number of stb/ack beats and CAB bursts are allowed. When mx_cyc_i goes low, go to IDLE and set last_owner to x.
- Slave outputs in OWNx equal the master x inputs, with s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i. In IDLE, all slave outputs are 0.
- mx_ack_o = s_ack_i & gnt_o[x]; likewise for err. The non-owner never sees ack or err.
- The non-owner's cyc/stb are ignored. It waits with no timeout of its own.
- Reset values: state IDLE; gnt_o 0; s_cyc_o, s_stb_o, s_we_o, s_cab_o 0; s_adr_o, s_sel_o, s_dat_o 0; all ack/err 0; arb_to_o 0; watchdog counter 0.
- Asynchronous reset mid-cycle: everything returns to reset values immediately; no ack is delivered.

## Timing
- Grant latency: a request sampled in IDLE at edge N produces gnt_o and s_cyc_o in the cycle after edge N (one-cycle latency). Slave handshake latency is pass-through combinational.
- Release: the owner drops cyc in cycle K. gnt_o is 0 in cycle K+1, and a new grant appears at the earliest in cycle K+2. There is always exactly one idle cycle between owners.
- Simultaneous release and other-request: the other master is granted after the mandatory idle cycle.
- Back-to-back request by the same master after release:
  - Allowed if the other master is idle.
  - If the other master is requesting, the round-robin hands the bus over.
- A CAB burst is never broken by the arbiter.

## Configuration
- Macro VGA_WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter runs while s_stb_o & !s_ack_i & !s_err_i. It clears on ack, err, or stb low.
  - When the counter reaches TIMEOUT, in that same cycle: mx_err_o = 1 for the owner, s_stb_o forced to 0, arb_to_o = 1, and the counter clears.
  - The grant is kept until the owner drops cyc.
- Undefined: no counter; arb_to_o tied to 0; no forced errors.

## Test plan
- Reset, then m0_cyc_i = 1 with an 8-beat CAB read; slave acks every cycle -> gnt_o = 01 one cycle after the request; 8 m0_ack_o pulses; m1_ack_o stays 0; s_cab_o = 1 throughout.
- m0 and m1 request in the same cycle from reset -> m0 granted first. After m0 drops cyc: one idle cycle (gnt_o = 00), then gnt_o = 10.
- m0 requests continuously back-to-back while m1 holds a request -> grants alternate 01, 00, 10, 00, 01.
- m1 mid-burst when m0 requests -> m1 keeps the grant until its cyc falls; s_adr_o never shows m0_adr_i during the burst.
- With VGA_WB_ARB_TIMEOUT_EN and TIMEOUT = 16, slave never acks -> after 16 stb cycles: arb_to_o and m0_err_o pulse for one cycle, and s_stb_o goes low. Without the macro, stb stays high indefinitely.
- rst_nreset_i pulsed low mid-burst -> gnt_o, s_cyc_o, and ack/err are 0 asynchronously. After release, a fresh request is granted with one-cycle latency.
